// File: rtl/fp_align_shifter.sv
// Pipelined significand shifter: right shifts align with guard/round/sticky, left shifts normalise.
// One power-of-two shift level per register stage; the whole pipe stalls when the output is held.
module fp_align_shifter #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_mag,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic [2:0]       out_grs,
  output logic             out_sat
);

  localparam int EW = WIDTH + 2;
  localparam logic [EW-1:0]    ONES_E = '1;
  localparam logic [WIDTH-1:0] ONES_W = '1;

  logic          advance;
  logic          entry_sat;
  logic          entry_sticky;
  logic [EW-1:0] entry_ext;

  // Oversize right shifts are resolved once at entry; later stages then only shift zeros.
  assign entry_sat    = !in_dir && (32'(in_shamt) >= 32'(EW));
  assign entry_ext    = entry_sat ? '0 : {in_mag, 2'b00};
  assign entry_sticky = entry_sat && (|in_mag);

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < SHW; gi++) begin : stage
    localparam int K = SHW - 1 - gi;
    localparam int D = 1 << K;

    logic          prev_valid;
    logic          prev_sign;
    logic          prev_dir;
    logic          prev_sticky;
    logic          prev_sat;
    logic [K:0]    prev_shamt;
    logic [EW-1:0] prev_ext;

    logic [EW-1:0] ext_next;
    logic          sticky_next;
    logic          sat_next;

    logic          valid_reg;
    logic          sign_reg;
    logic          sticky_reg;
    logic          sat_reg;
    logic [EW-1:0] ext_reg;

    if (gi == 0) begin : g_src
      assign prev_valid  = in_valid;
      assign prev_sign   = in_sign;
      assign prev_dir    = in_dir;
      assign prev_sticky = entry_sticky;
      assign prev_sat    = entry_sat;
      assign prev_shamt  = in_shamt;
      assign prev_ext    = entry_ext;
    end else begin : g_src
      assign prev_valid  = stage[gi-1].valid_reg;
      assign prev_sign   = stage[gi-1].sign_reg;
      assign prev_dir    = stage[gi-1].g_carry.dir_reg;
      assign prev_sticky = stage[gi-1].sticky_reg;
      assign prev_sat    = stage[gi-1].sat_reg;
      assign prev_shamt  = stage[gi-1].g_carry.rest_reg;
      assign prev_ext    = stage[gi-1].ext_reg;
    end

    always_comb begin
      ext_next    = prev_ext;
      sticky_next = prev_sticky;
      sat_next    = prev_sat;
      if (prev_shamt[K]) begin
        if (prev_dir) begin
          // Left: g/r stay zero, any 1 pushed past the MSB flags saturation.
          ext_next = {prev_ext[EW-1:2] << D, 2'b00};
          sat_next = prev_sat | (|(prev_ext[EW-1:2] & ~(ONES_W >> D)));
        end else begin
          ext_next    = prev_ext >> D;
          sticky_next = prev_sticky | (|(prev_ext & ~(ONES_E << D)));
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg  <= 1'b0;
        sign_reg   <= 1'b0;
        sticky_reg <= 1'b0;
        sat_reg    <= 1'b0;
        ext_reg    <= '0;
      end else if (advance) begin
        valid_reg  <= prev_valid;
        sign_reg   <= prev_sign;
        sticky_reg <= sticky_next;
        sat_reg    <= sat_next;
        ext_reg    <= ext_next;
      end
    end

    // Direction and the not-yet-consumed shift bits only travel as far as they are needed.
    if (K > 0) begin : g_carry
      logic         dir_reg;
      logic [K-1:0] rest_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dir_reg  <= 1'b0;
          rest_reg <= '0;
        end else if (advance) begin
          dir_reg  <= prev_dir;
          rest_reg <= prev_shamt[K-1:0];
        end
      end
    end
  end

  assign out_valid = stage[SHW-1].valid_reg;
  assign out_sign  = stage[SHW-1].sign_reg;
  assign out_mag   = stage[SHW-1].ext_reg[EW-1:2];
  assign out_grs   = {stage[SHW-1].ext_reg[1:0], stage[SHW-1].sticky_reg};
  assign out_sat   = stage[SHW-1].sat_reg;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed bench for fp_align_shifter: arithmetic reference model, per-cycle output checker,
// literal expectations for the hand-worked vectors, stall/hold and mid-stream reset checks.
module tb_fp_align_shifter;
  localparam int WIDTH = 24;
  localparam int SHW   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_sign, in_dir;
  logic [23:0] in_mag;
  logic [4:0]  in_shamt;
  logic        out_valid, out_ready, out_sign, out_sat;
  logic [23:0] out_mag;
  logic [2:0]  out_grs;

  fp_align_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_mag(in_mag), .in_shamt(in_shamt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mag(out_mag), .out_grs(out_grs), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic        sign;
    logic [23:0] mag;
    logic [2:0]  grs;
    logic        sat;
    bit          has_lit;
    logic [23:0] lmag;
    logic [2:0]  lgrs;
    logic        lsat;
    bit          chk_lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Reference: the whole shift done in one wide integer, then fields picked off.
  function automatic void model(input logic [23:0] mag, input logic [4:0] sh, input logic dir,
                                output logic [23:0] om, output logic [2:0] og, output logic os);
    logic [63:0] v, lost;
    if (dir) begin
      v  = 64'(mag) << sh;
      om = v[23:0];
      og = 3'b000;
      os = (v >> 24) != 0;
    end else if (sh >= 5'd26) begin
      om = '0;
      og = {2'b00, mag != 0};
      os = 1'b1;
    end else begin
      v    = 64'(mag) << 2;
      lost = v & ((64'd1 << sh) - 64'd1);
      v    = v >> sh;
      om   = v[25:2];
      og   = {v[1], v[0], lost != 0};
      os   = 1'b0;
    end
  endfunction

  task automatic send(input logic s, input logic [23:0] m, input logic [4:0] sh, input logic d,
                      input bit lit, input logic [23:0] lm, input logic [2:0] lg, input logic ls,
                      input bit lat);
    exp_t e;
    int n = 0;
    model(m, sh, d, e.mag, e.grs, e.sat);
    e.sign = s; e.has_lit = lit; e.lmag = lm; e.lgrs = lg; e.lsat = ls; e.chk_lat = lat;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_mag = m; in_shamt = sh; in_dir = d;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(n), 0);
    end else begin
      e.acc = cycle;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Per-cycle checker, sampled between edges after the stimulus has settled.
  logic        hold_v = 1'b0;
  logic        h_sign, h_sat;
  logic [23:0] h_mag;
  logic [2:0]  h_grs;
  exp_t        ce;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_mag", 32'(out_mag), 32'(h_mag));
        chk("hold_grs", 32'(out_grs), 32'(h_grs));
        chk("hold_sat", 32'(out_sat), 32'(h_sat));
        chk("hold_sign", 32'(out_sign), 32'(h_sign));
      end
      hold_v = out_valid && !out_ready;
      h_mag = out_mag; h_grs = out_grs; h_sat = out_sat; h_sign = out_sign;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got mag %0h, expected no beat", out_mag);
        end else begin
          ce = exp_q.pop_front();
          chk("mag", 32'(out_mag), 32'(ce.mag));
          chk("grs", 32'(out_grs), 32'(ce.grs));
          chk("sat", 32'(out_sat), 32'(ce.sat));
          chk("sign", 32'(out_sign), 32'(ce.sign));
          if (ce.has_lit) begin
            chk("lit_mag", 32'(out_mag), 32'(ce.lmag));
            chk("lit_grs", 32'(out_grs), 32'(ce.lgrs));
            chk("lit_sat", 32'(out_sat), 32'(ce.lsat));
          end
          if (ce.chk_lat) chk("latency", 32'(cycle - ce.acc), SHW);
        end
      end
    end
  end

  // Hand-worked vectors: sign, mag, shamt, dir, expected mag, grs, sat
  typedef struct {
    logic s; logic [23:0] m; logic [4:0] sh; logic d;
    logic [23:0] em; logic [2:0] eg; logic es;
  } vec_t;
  vec_t vecs[14] = '{
    '{1'b0, 24'hC00001, 5'd1,  1'b0, 24'h600000, 3'b100, 1'b0},
    '{1'b1, 24'h00000F, 5'd3,  1'b0, 24'h000001, 3'b111, 1'b0},
    '{1'b0, 24'h800000, 5'd25, 1'b0, 24'h000000, 3'b010, 1'b0},  // bit 23 lands on round
    '{1'b1, 24'h000001, 5'd31, 1'b0, 24'h000000, 3'b001, 1'b1},
    '{1'b0, 24'h000000, 5'd31, 1'b0, 24'h000000, 3'b000, 1'b1},
    '{1'b0, 24'h000003, 5'd22, 1'b1, 24'hC00000, 3'b000, 1'b0},
    '{1'b1, 24'h000003, 5'd23, 1'b1, 24'h800000, 3'b000, 1'b1},
    '{1'b0, 24'h000003, 5'd0,  1'b1, 24'h000003, 3'b000, 1'b0},
    '{1'b1, 24'hABCDEF, 5'd0,  1'b0, 24'hABCDEF, 3'b000, 1'b0},
    '{1'b0, 24'h000000, 5'd31, 1'b1, 24'h000000, 3'b000, 1'b0},
    '{1'b1, 24'h123456, 5'd26, 1'b0, 24'h000000, 3'b001, 1'b1},
    '{1'b0, 24'h000001, 5'd24, 1'b1, 24'h000000, 3'b000, 1'b1},
    '{1'b1, 24'hFFFFFF, 5'd24, 1'b0, 24'h000000, 3'b111, 1'b0},
    '{1'b0, 24'h000003, 5'd2,  1'b0, 24'h000000, 3'b110, 1'b0}
  };

  initial begin
    in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; in_shamt = '0; in_dir = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_mag", 32'(out_mag), 0);
    chk("rst_grs", 32'(out_grs), 0);
    chk("rst_sat", 32'(out_sat), 0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(in_ready), 1);

    foreach (vecs[i]) begin
      send(vecs[i].s, vecs[i].m, vecs[i].sh, vecs[i].d, 1'b1,
           vecs[i].em, vecs[i].eg, vecs[i].es, 1'b1);
      idle();
      drain();
    end

    // Ten back-to-back beats with the sink stalled for four cycles.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [23:0] m;
          logic [4:0]  sh;
          logic [4:0]  iv;
          iv = 5'(i);
          m  = 24'h9A0000 ^ (24'(i) * 24'h013579);
          sh = 5'((i * 3) % 32);
          send(iv[1], m, sh, iv[0], 1'b0, '0, '0, 1'b0, 1'b0);
        end
        idle();
      end
      begin
        repeat (7) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight, head beat stalled at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 24'h00F000 + 24'(i), 5'(i + 4), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle();
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("stall_head_valid", 32'(out_valid), 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_drop_valid", 32'(out_valid), 0);
    chk("async_drop_mag", 32'(out_mag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    send(1'b1, 24'hC00001, 5'd1, 1'b0, 1'b1, 24'h600000, 3'b100, 1'b0, 1'b1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end
endmodule
